xnor_cell: RTL and testbench



---
 rtl/xnor_cell_pkg.sv | 26 ++
 rtl/xnor_cell_if.sv | 39 +++
 rtl/xnor_popcount.sv | 25 ++
 rtl/xnor_cell.sv | 81 ++++++++
 tb/tb_xnor_cell.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/xnor_cell_pkg.sv
// ---------------------------------------------------------------------------
// xnor_cell_pkg
//   Shared constants, helper function and result type for the xnor_cell
//   compare/match stage.
//   MAX_WIDTH      largest legal operand width
//   cnt_width(w)   bits needed to hold a match count of 0..w
//   xnor_result_t  full-width result record {out, eq, match_cnt}, sized for
//                  MAX_WIDTH so any instance's result fits in it
// ---------------------------------------------------------------------------
package xnor_cell_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int MAX_CNT_W = cnt_width(MAX_WIDTH);

    typedef struct packed {
        logic [MAX_WIDTH-1:0] out;
        logic                 eq;
        logic [MAX_CNT_W-1:0] match_cnt;
    } xnor_result_t;

endpackage

// File: rtl/xnor_cell_if.sv
// ---------------------------------------------------------------------------
// xnor_cell_if
//   Operand/result bundle for xnor_cell.
//   a, b       operands (WIDTH bits)
//   in_valid   qualifies a/b for capture
//   out        registered ~(a ^ b)
//   out_valid  one-cycle-late copy of an accepted in_valid
//   eq         registered all-bits-equal flag
//   match_cnt  registered count of matching bit positions
//   master: drives operands, observes results.
//   slave : the xnor_cell side.
// ---------------------------------------------------------------------------
interface xnor_cell_if
    import xnor_cell_pkg::*;
#(
    parameter int WIDTH = 1
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             eq;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output a, b, in_valid,
        input  out, out_valid, eq, match_cnt
    );

    modport slave (
        input  a, b, in_valid,
        output out, out_valid, eq, match_cnt
    );

endinterface

// File: rtl/xnor_popcount.sv
// ---------------------------------------------------------------------------
// xnor_popcount
//   Combinational population count.
//   bits   in   WIDTH                 vector to count
//   count  out  cnt_width(WIDTH)      number of ones in bits, 0..WIDTH
// ---------------------------------------------------------------------------
module xnor_popcount
    import xnor_cell_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0]            bits,
    output logic [cnt_width(WIDTH)-1:0] count
);

    localparam int CNT_W = cnt_width(WIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/xnor_cell.sv
// ---------------------------------------------------------------------------
// xnor_cell
//   Registered bitwise XNOR / equality unit with 1-clock latency.
//   clk    in  single clock, all state on rising edge
//   rst_n  in  asynchronous active-low reset, clears every output register
//   bus    xnor_cell_if.slave:
//            a, b, in_valid            operands and their qualifier
//            out, eq, match_cnt        results, held while in_valid is low
//            out_valid                 high one clock after each accepted input
//   Build option XNOR_CELL_MATCH_CNT_EN: when defined, a popcount of the
//   matching bits is registered onto match_cnt; otherwise match_cnt is tied
//   to zero and no counting logic exists.
// ---------------------------------------------------------------------------
module xnor_cell
    import xnor_cell_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    xnor_cell_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("xnor_cell: WIDTH must lie in 1..64");
    end

    logic [WIDTH-1:0] match_vec;
    logic [WIDTH-1:0] out_q;
    logic             eq_q;
    logic             valid_q;

    assign match_vec = ~(bus.a ^ bus.b);

    // Results only load when in_valid is high, so unknown operands on idle
    // cycles never reach the registers; out_valid simply follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            eq_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q <= match_vec;
                eq_q  <= &match_vec;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.eq        = eq_q;
    assign bus.out_valid = valid_q;

`ifdef XNOR_CELL_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    xnor_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .bits  (match_vec),
        .count (cnt_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.in_valid) begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_xnor_cell.sv
// ---------------------------------------------------------------------------
// tb_xnor_cell
//   Scoreboard bench for xnor_cell. Three instances (WIDTH 1, 8, 16) share
//   clock and reset. The driver pushes the reference result for every
//   accepted input; one monitor per instance pops and compares each cycle.
//   Honours XNOR_CELL_MATCH_CNT_EN for the expected match count.
// ---------------------------------------------------------------------------
module tb_xnor_cell;
    import xnor_cell_pkg::*;

    logic clk;
    logic rst_n;

    xnor_cell_if #(.WIDTH(1))  bus_w1  ();
    xnor_cell_if #(.WIDTH(8))  bus_w8  ();
    xnor_cell_if #(.WIDTH(16)) bus_w16 ();

    xnor_cell #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
    xnor_cell #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(bus_w8));
    xnor_cell #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(bus_w16));

    int checks = 0;
    int errors = 0;

    xnor_result_t exp_q [3][$];
    xnor_result_t last_exp [3];
    int           widths [3] = '{1, 8, 16};
    string        names  [3] = '{"w1", "w8", "w16"};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: out is the set of agreeing bit positions, eq means every
    // position agrees, match_cnt is how many agree.
    function automatic xnor_result_t refModel(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input int w);
        xnor_result_t r;
        logic [63:0]  mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        r.out = ~(a ^ b) & mask;
        r.eq  = ((a & mask) == (b & mask));
`ifdef XNOR_CELL_MATCH_CNT_EN
        r.match_cnt = MAX_CNT_W'($countones(r.out));
`else
        r.match_cnt = '0;
`endif
        return r;
    endfunction

    function automatic xnor_result_t packResult(input logic [63:0] o,
                                                input logic e,
                                                input logic [MAX_CNT_W-1:0] c);
        xnor_result_t r;
        r.out       = o;
        r.eq        = e;
        r.match_cnt = c;
        return r;
    endfunction

    task automatic checkValid(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: out_valid=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input xnor_result_t act,
                               input xnor_result_t exp);
        checks++;
        if (act.out !== exp.out) begin
            errors++;
            $display("[TB] FAIL %s: out=%h expected %h at %0t", name, act.out, exp.out, $time);
        end
        checks++;
        if (act.eq !== exp.eq) begin
            errors++;
            $display("[TB] FAIL %s: eq=%b expected %b at %0t", name, act.eq, exp.eq, $time);
        end
        checks++;
        if (act.match_cnt !== exp.match_cnt) begin
            errors++;
            $display("[TB] FAIL %s: match_cnt=%0d expected %0d at %0t",
                     name, act.match_cnt, exp.match_cnt, $time);
        end
    endtask

    // One monitor step per instance: a queued expectation means a result is
    // due this cycle; otherwise out_valid must be low and values held.
    task automatic monitorStep(input int idx, input logic valid, input xnor_result_t act);
        xnor_result_t e;
        if (!rst_n) begin
            checkValid({names[idx], "_rst_valid"}, valid, 1'b0);
            checkOutput({names[idx], "_rst"}, act, '0);
            exp_q[idx].delete();
            last_exp[idx] = '0;
        end else if (exp_q[idx].size() > 0) begin
            e = exp_q[idx].pop_front();
            checkValid({names[idx], "_valid"}, valid, 1'b1);
            checkOutput({names[idx], "_result"}, act, e);
            last_exp[idx] = e;
        end else begin
            checkValid({names[idx], "_idle_valid"}, valid, 1'b0);
            checkOutput({names[idx], "_hold"}, act, last_exp[idx]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        monitorStep(0, bus_w1.out_valid,
                    packResult(64'(bus_w1.a ^ bus_w1.a) | 64'(bus_w1.out), bus_w1.eq,
                               MAX_CNT_W'(bus_w1.match_cnt)));
    end

    always @(posedge clk) begin
        #1;
        monitorStep(1, bus_w8.out_valid,
                    packResult(64'(bus_w8.out), bus_w8.eq, MAX_CNT_W'(bus_w8.match_cnt)));
    end

    always @(posedge clk) begin
        #1;
        monitorStep(2, bus_w16.out_valid,
                    packResult(64'(bus_w16.out), bus_w16.eq, MAX_CNT_W'(bus_w16.match_cnt)));
    end

    task automatic clearValids();
        bus_w1.in_valid  = 1'b0;
        bus_w8.in_valid  = 1'b0;
        bus_w16.in_valid = 1'b0;
    endtask

    // Drive one instance on the falling edge; the reference result is queued
    // for the monitor when the input is qualified.
    task automatic applyStimulus(input int idx, input logic [63:0] a,
                                 input logic [63:0] b, input logic v);
        @(negedge clk);
        clearValids();
        case (idx)
            0: begin bus_w1.a  = a[0];    bus_w1.b  = b[0];    bus_w1.in_valid  = v; end
            1: begin bus_w8.a  = a[7:0];  bus_w8.b  = b[7:0];  bus_w8.in_valid  = v; end
            default: begin
                bus_w16.a = a[15:0]; bus_w16.b = b[15:0]; bus_w16.in_valid = v;
            end
        endcase
        if (v) exp_q[idx].push_back(refModel(a, b, widths[idx]));
    endtask

    initial begin
        rst_n = 1'b0;
        bus_w1.a  = '0; bus_w1.b  = '0;
        bus_w8.a  = '0; bus_w8.b  = '0;
        bus_w16.a = '0; bus_w16.b = '0;
        clearValids();
        for (int i = 0; i < 3; i++) last_exp[i] = '0;

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single-bit gate truth table, back to back.
        applyStimulus(0, 64'd0, 64'd0, 1'b1);
        applyStimulus(0, 64'd0, 64'd1, 1'b1);
        applyStimulus(0, 64'd1, 64'd0, 1'b1);
        applyStimulus(0, 64'd1, 64'd1, 1'b1);
        applyStimulus(0, 64'd0, 64'd1, 1'b0);

        // Full match and full mismatch on 8 bits.
        applyStimulus(1, 64'hA5, 64'hA5, 1'b1);
        applyStimulus(1, 64'hA5, 64'h5A, 1'b1);

        // Partial match then three idle cycles with toggling operands.
        applyStimulus(1, 64'hF0, 64'hFF, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 64'($urandom), 64'($urandom), 1'b0);

        // Asynchronous reset between edges with a result in flight.
        applyStimulus(1, 64'h3C, 64'h3D, 1'b1);
        applyStimulus(1, 64'h11, 64'h11, 1'b1);
        #2 rst_n = 1'b0;
        clearValids();
        #1;
        checkValid("w8_async_rst_valid", bus_w8.out_valid, 1'b0);
        checkOutput("w8_async_rst",
                    packResult(64'(bus_w8.out), bus_w8.eq, MAX_CNT_W'(bus_w8.match_cnt)), '0);
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 64'($urandom), 64'($urandom), 1'b0);

        // 16-bit corner patterns, then random traffic.
        applyStimulus(2, 64'hFFFF, 64'hFFFF, 1'b1);
        applyStimulus(2, 64'h0000, 64'hFFFF, 1'b1);
        applyStimulus(2, 64'h8001, 64'h0001, 1'b1);
        for (int i = 0; i < 1000; i++)
            applyStimulus(2, 64'($urandom), 64'($urandom), 1'b1);
        for (int i = 0; i < 200; i++)
            applyStimulus(2, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)));

        applyStimulus(2, 64'd0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("[TB] FAIL %s_drain: %0d results outstanding, expected 0",
                         names[i], exp_q[i].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
